// File: rtl/core_ibex_fcov_pkg.sv
// core_ibex_fcov_pkg: shared types for the ID-stage stall episode tracker.
package core_ibex_fcov_pkg;
  localparam int unsigned StallLenW = 8;
  typedef enum logic [2:0] {
    STALL_LD_HZ,
    STALL_MEM,
    STALL_MULTDIV,
    STALL_BRANCH,
    STALL_JUMP
  } stall_cause_e;
  typedef struct packed {
    stall_cause_e         cause;
    logic [StallLenW-1:0] len;
    logic                 mixed;
    logic                 sat;
    logic                 flushed;
  } stall_rec_t;
endpackage

// File: rtl/core_ibex_fcov_stall_fifo.sv
// core_ibex_fcov_stall_fifo: Depth-entry sync FIFO, valid/ready, same-cycle push+pop when full.
module core_ibex_fcov_stall_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  output logic             full_o,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [Width-1:0] rdata_o
);
  localparam int unsigned AW = $clog2(Depth);
  logic [AW:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [Width-1:0] mem_q [Depth];
  logic empty, wr, rd;
  always_comb begin
    empty   = wptr_q == rptr_q;
    full_o  = (wptr_q ^ rptr_q) == {1'b1, {AW{1'b0}}};
    rd      = ~empty & ready_i;
    wr      = push_i & (~full_o | rd);
    wptr_d  = wptr_q + (AW+1)'(wr);
    rptr_d  = rptr_q + (AW+1)'(rd);
    valid_o = ~empty;
    rdata_o = empty ? '0 : mem_q[rptr_q[AW-1:0]];
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end
  always_ff @(posedge clk_i) begin
    if (wr) mem_q[wptr_q[AW-1:0]] <= wdata_i;
  end
endmodule

// File: rtl/core_ibex_fcov_stall_tracker.sv
// core_ibex_fcov_stall_tracker: groups stalled ID cycles into episodes and queues one record each.
module core_ibex_fcov_stall_tracker
  import core_ibex_fcov_pkg::*;
#(
  parameter int unsigned LenW  = StallLenW,
  parameter int unsigned Depth = 4,
  parameter int unsigned OvfW  = 16
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            instr_valid_i,
  input  logic            stall_ld_hz_i,
  input  logic            stall_mem_i,
  input  logic            stall_multdiv_i,
  input  logic            stall_branch_i,
  input  logic            stall_jump_i,
  output logic            rec_valid_o,
  input  logic            rec_ready_i,
  output stall_rec_t      rec_o,
  output logic [OvfW-1:0] dropped_cnt_o,
  output logic            overflow_o
);
  typedef enum logic {IDLE, STALLING} state_e;
  state_e state_q, state_d;
  stall_cause_e cause_q, cause_d, cause_now;
  logic [LenW-1:0] len_q, len_d;
  logic [OvfW-1:0] dropped_q, dropped_d;
  logic mixed_q, mixed_d, sat_q, sat_d, overflow_q, overflow_d;
  logic [4:0] sv;
  logic stall, multi, push, pop, full, drop;
  stall_rec_t rec_in, rec_out;
  // Gating by instr_valid_i first keeps X on stall_* out of every decision.
  always_comb begin
    sv        = {5{instr_valid_i}} & {stall_ld_hz_i, stall_mem_i, stall_multdiv_i,
                                      stall_branch_i, stall_jump_i};
    stall     = |sv;
    multi     = |(sv & (sv - 5'd1));
    cause_now = sv[4] ? STALL_LD_HZ : sv[3] ? STALL_MEM : sv[2] ? STALL_MULTDIV :
                sv[1] ? STALL_BRANCH : STALL_JUMP;
    state_d   = state_q;
    cause_d   = cause_q;
    len_d     = len_q;
    mixed_d   = mixed_q;
    sat_d     = sat_q;
    push      = 1'b0;
    if (state_q == IDLE) begin
      if (stall) begin
        state_d = STALLING;
        cause_d = cause_now;
        len_d   = LenW'(1);
        mixed_d = multi;
        sat_d   = 1'b0;
      end
    end else if (stall) begin
      len_d   = &len_q ? len_q : len_q + LenW'(1);
      sat_d   = sat_q | &len_q;
      mixed_d = mixed_q | multi | (cause_now != cause_q);
    end else begin
      push    = 1'b1;
      state_d = IDLE;
    end
    rec_in     = '{cause: cause_q, len: len_q, mixed: mixed_q, sat: sat_q,
                   flushed: ~instr_valid_i};
    pop        = rec_valid_o & rec_ready_i;
    drop       = push & full & ~pop;
    dropped_d  = (drop & ~&dropped_q) ? dropped_q + OvfW'(1) : dropped_q;
    overflow_d = overflow_q | drop;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      cause_q    <= STALL_LD_HZ;
      len_q      <= '0;
      mixed_q    <= 1'b0;
      sat_q      <= 1'b0;
      dropped_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cause_q    <= cause_d;
      len_q      <= len_d;
      mixed_q    <= mixed_d;
      sat_q      <= sat_d;
      dropped_q  <= dropped_d;
      overflow_q <= overflow_d;
    end
  end
  core_ibex_fcov_stall_fifo #(
    .Width($bits(stall_rec_t)),
    .Depth(Depth)
  ) u_fifo (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .push_i (push),
    .wdata_i(rec_in),
    .full_o (full),
    .valid_o(rec_valid_o),
    .ready_i(rec_ready_i),
    .rdata_o(rec_out)
  );
  assign rec_o         = rec_out;
  assign dropped_cnt_o = dropped_q;
  assign overflow_o    = overflow_q;
endmodule
